// File: rtl/vfpu_cfg_master_if.sv
// Peripheral config bus between the VFPU cfg master (initiator) and the
// HWPE slave register file. The request channel is add/wen/be/data/id
// qualified by req/gnt; the response channel is r_valid/r_data/r_id.
interface vfpu_cfg_master_if #(
  parameter int ID_WIDTH = 16
);
  logic                req;
  logic                gnt;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic                r_valid;
  logic [31:0]         r_data;
  logic [ID_WIDTH-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_valid, r_data, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_valid, r_data, r_id
  );
endinterface

// File: rtl/vfpu_cfg_master.sv
// VFPU HWPE config-port master: accepts one packed job, acquires a context,
// writes N_REGS IO params, writes the trigger, waits for completion and
// pulses done_o with the acquired context id.
// Optional build macro VFPU_CFG_STATUS_POLL_EN: completion is detected by
// polling the status register instead of evt_i.
module vfpu_cfg_master #(
  parameter int          N_REGS       = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          ID_WIDTH     = 16,
  parameter int          MASTER_ID    = 1,
  parameter int          RETRY_CYCLES = 8,
  parameter int          POLL_CYCLES  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 job_valid_i,
  output logic                 job_ready_o,
  input  logic [N_REGS*32-1:0] job_params_i,
  output logic                 done_o,
  output logic [7:0]           job_id_o,
  output logic                 busy_o,
  input  logic                 evt_i,
  vfpu_cfg_master_if.master    periph
);

  localparam int IDX_W   = $clog2(N_REGS + 1);
  localparam int SEL_W   = $clog2(N_REGS);
  localparam int CNT_MAX = (RETRY_CYCLES > POLL_CYCLES) ? RETRY_CYCLES : POLL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_REGS - 1);
  localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_CYCLES - 1);
`ifdef VFPU_CFG_STATUS_POLL_EN
  localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_CYCLES - 1);
`endif

  typedef enum logic [3:0] {
    IDLE,
    ACQ_REQ,
    ACQ_RESP,
    RETRY,
    WR_REG,
    TRIG,
    WAIT_DONE,
    POLL_WAIT,
    POLL_REQ,
    POLL_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       job_id_q, job_id_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             params_load;
  logic [31:0]      params_q [N_REGS];
  logic             rsp_ok;

  // Read responses addressed to another master are not ours.
  assign rsp_ok = periph.r_valid && (periph.r_id == ID_WIDTH'(MASTER_ID));

`ifdef VFPU_CFG_STATUS_POLL_EN
  logic unused_evt;
  assign unused_evt = evt_i;
`else
  logic unused_rdata;
  assign unused_rdata = ^periph.r_data[30:8];
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      job_id_q <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values, independent of statement order.
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      job_id_q <= job_id_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  // Job parameter capture on accept.
  // NOTE: params_q has no reset; it is always loaded on accept before any
  // entry is read, so a reset would only cost a wide reset fan-out.
  always_ff @(posedge clk_i) begin
    if (params_load) begin
      for (int i = 0; i < N_REGS; i++) begin
        params_q[i] <= job_params_i[32*i +: 32];
      end
    end
  end

  // Next-state logic and bus request decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave a value unassigned and infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    job_id_d    = job_id_q;
    done_d      = 1'b0;
    params_load = 1'b0;
    periph.req  = 1'b0;
    periph.add  = '0;
    periph.wen  = 1'b0;
    periph.data = '0;

    unique case (state_q)
      IDLE: begin
        if (job_valid_i && ready_q) begin
          params_load = 1'b1;
          state_d     = ACQ_REQ;
        end
      end
      ACQ_REQ: begin
        periph.req = 1'b1;
        periph.wen = 1'b1;
        periph.add = BASE_ADDR + 32'h04;
        if (periph.gnt) state_d = ACQ_RESP;
      end
      ACQ_RESP: begin
        if (rsp_ok) begin
          if (periph.r_data[31]) begin
            cnt_d   = '0;
            state_d = RETRY;
          end else begin
            job_id_d = periph.r_data[7:0];
            idx_d    = '0;
            state_d  = WR_REG;
          end
        end
      end
      RETRY: begin
        if (cnt_q == RETRY_LAST) state_d = ACQ_REQ;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      WR_REG: begin
        periph.req  = 1'b1;
        periph.add  = BASE_ADDR + 32'h40 + (32'(idx_q) << 2);
        periph.data = params_q[idx_q[SEL_W-1:0]];
        if (periph.gnt) begin
          if (idx_q == IDX_LAST) state_d = TRIG;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      TRIG: begin
        periph.req = 1'b1;
        periph.add = BASE_ADDR;
        if (periph.gnt) begin
`ifdef VFPU_CFG_STATUS_POLL_EN
          cnt_d   = '0;
          state_d = POLL_WAIT;
`else
          state_d = WAIT_DONE;
`endif
        end
      end
`ifdef VFPU_CFG_STATUS_POLL_EN
      POLL_WAIT: begin
        if (cnt_q == POLL_LAST) state_d = POLL_REQ;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      POLL_REQ: begin
        periph.req = 1'b1;
        periph.wen = 1'b1;
        periph.add = BASE_ADDR + 32'h0C;
        if (periph.gnt) state_d = POLL_RESP;
      end
      POLL_RESP: begin
        if (rsp_ok) begin
          if (periph.r_data == 32'h0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = POLL_WAIT;
          end
        end
      end
`else
      WAIT_DONE: begin
        if (evt_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Ready is withheld in the done cycle, so the next job is taken at the
    // earliest one cycle after the done pulse.
    ready_d = (state_d == IDLE) && !done_d;
  end

  assign job_ready_o = ready_q;
  assign done_o      = done_q;
  assign job_id_o    = job_id_q;
  assign busy_o      = (state_q != IDLE);
  assign periph.be   = 4'hF;
  assign periph.id   = ID_WIDTH'(MASTER_ID);

endmodule

// File: tb/tb_vfpu_cfg_master.sv
// Directed bench for vfpu_cfg_master: a negedge-driven bus slave model logs
// every granted transaction; the main sequence runs jobs and compares the
// log and outputs against hand-derived expectations.
module tb_vfpu_cfg_master;
  localparam int          N     = 16;
  localparam int          MID   = 1;
  localparam int          RETRY = 8;
  localparam int          POLL  = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef VFPU_CFG_STATUS_POLL_EN
  localparam int EVT_DELAY = 3;
`else
  localparam int EVT_DELAY = 20;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           job_valid = 1'b0;
  logic           evt = 1'b0;
  logic [N*32-1:0] job_params = '0;
  logic           job_ready, done, busy;
  logic [7:0]     job_id;

  vfpu_cfg_master_if #(.ID_WIDTH(16)) bus ();

  vfpu_cfg_master #(
    .N_REGS(N), .BASE_ADDR(BASE), .ID_WIDTH(16), .MASTER_ID(MID),
    .RETRY_CYCLES(RETRY), .POLL_CYCLES(POLL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .job_valid_i(job_valid), .job_ready_o(job_ready), .job_params_i(job_params),
    .done_o(done), .job_id_o(job_id), .busy_o(busy), .evt_i(evt),
    .periph(bus)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave model state
  bit          gnt_random = 0;
  bit          bad_id_next = 0;
  logic [31:0] rsp_q[$];
  int          rsp_stage = 0;
  logic [31:0] rsp_next = '0;
  logic [31:0] log_add[$];
  logic        log_wen[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  int          cyc = 0;
  int          trig_cnt = 0;
  int          req_seen = 0;
  int          done_cnt = 0;
  int          stable_err = 0;
  int          n_at_trig = 0;
  bit          prev_pending = 0;
  logic [31:0] prev_add, prev_data;
  logic        prev_wen;

  // Bus slave: responds one cycle after a granted read, logs grants and
  // watches request stability while stalled.
  initial begin
    bus.gnt = 1'b0; bus.r_valid = 1'b0; bus.r_data = '0; bus.r_id = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rsp_stage == 2) begin
        bus.r_valid = 1'b1; bus.r_id = 16'd5; bus.r_data = 32'h77; rsp_stage = 1;
      end else if (rsp_stage == 1) begin
        bus.r_valid = 1'b1; bus.r_id = 16'(MID); bus.r_data = rsp_next; rsp_stage = 0;
      end else begin
        bus.r_valid = 1'b0; bus.r_id = '0; bus.r_data = '0;
      end
      bus.gnt = gnt_random ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (!rst_n) begin
        prev_pending = 0;
        rsp_stage = 0;
      end else begin
        if (prev_pending && (!bus.req || bus.add !== prev_add ||
                             bus.wen !== prev_wen || bus.data !== prev_data))
          stable_err++;
        prev_pending = bus.req && !bus.gnt;
        prev_add = bus.add; prev_wen = bus.wen; prev_data = bus.data;
        if (bus.req) req_seen++;
        if (bus.req && bus.gnt) begin
          log_add.push_back(bus.add);
          log_wen.push_back(bus.wen);
          log_data.push_back(bus.data);
          log_cyc.push_back(cyc);
          if (bus.wen) begin
            rsp_next  = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'h0;
            rsp_stage = bad_id_next ? 2 : 1;
            bad_id_next = 0;
          end else if (bus.add == BASE) begin
            trig_cnt++;
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [N*32-1:0] make_params(input logic [31:0] seed);
    logic [N*32-1:0] p;
    for (int i = 0; i < N; i++) p[32*i +: 32] = seed + 32'(i) * 32'h0001_0011;
    return p;
  endfunction

  task automatic clear_log();
    log_add.delete(); log_wen.delete(); log_data.delete(); log_cyc.delete();
    trig_cnt = 0; done_cnt = 0; stable_err = 0;
  endtask

  task automatic send_job(input string tag, input logic [N*32-1:0] p);
    int t = 0;
    @(negedge clk);
    job_params = p;
    job_valid  = 1'b1;
    while (!job_ready && t < 50) begin @(negedge clk); t++; end
    check({tag, "_accept"}, 32'(job_ready), 32'd1);
    @(negedge clk);
    job_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_trigger(input string tag);
    int t = 0;
    while (trig_cnt == 0 && t < 2000) begin @(negedge clk); t++; end
    check({tag, "_trig_seen"}, 32'(trig_cnt), 32'd1);
    n_at_trig = log_add.size();
  endtask

  task automatic finish_job(input string tag, input logic [7:0] exp_id);
    int t = 0;
    wait_trigger(tag);
    repeat (EVT_DELAY) @(negedge clk);
    evt = 1'b1;
    @(negedge clk);
    evt = 1'b0;
`ifdef VFPU_CFG_STATUS_POLL_EN
    check({tag, "_evt_ignored"}, 32'(done), 32'd0);
`else
    check({tag, "_done_on_evt"}, 32'(done), 32'd1);
`endif
    while (!done && t < 500) begin @(negedge clk); t++; end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_job_id"}, 32'(job_id), 32'(exp_id));
    @(negedge clk);
    check({tag, "_done_width"}, 32'(done), 32'd0);
    check({tag, "_ready_after"}, 32'(job_ready), 32'd1);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
  endtask

  // Expected log up to the trigger: n_reads acquire reads, N writes, trigger.
  task automatic check_job_log(input string tag, input int n_reads, input logic [N*32-1:0] p);
    int e;
    check({tag, "_n_tx"}, 32'(n_at_trig), 32'(n_reads + N + 1));
    if (n_at_trig == n_reads + N + 1) begin
      for (int r = 0; r < n_reads; r++) begin
        check($sformatf("%s_acq_add%0d", tag, r), log_add[r], BASE + 32'h04);
        check($sformatf("%s_acq_wen%0d", tag, r), 32'(log_wen[r]), 32'd1);
      end
      for (int i = 0; i < N; i++) begin
        e = n_reads + i;
        check($sformatf("%s_wr_add%0d", tag, i), log_add[e], BASE + 32'h40 + 32'(4 * i));
        check($sformatf("%s_wr_wen%0d", tag, i), 32'(log_wen[e]), 32'd0);
        check($sformatf("%s_wr_data%0d", tag, i), log_data[e], p[32*i +: 32]);
      end
      e = n_reads + N;
      check({tag, "_trig_add"}, log_add[e], BASE);
      check({tag, "_trig_wen"}, 32'(log_wen[e]), 32'd0);
      check({tag, "_trig_data"}, log_data[e], 32'h0);
    end
  endtask

  initial begin
    logic [N*32-1:0] p;
    int t;
    int base_req;

    // Reset values
    #12;
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_add", bus.add, 32'h0);
    check("rst_wen", 32'(bus.wen), 32'd0);
    check("rst_data", bus.data, 32'h0);
    check("rst_be", 32'(bus.be), 32'hF);
    check("rst_id", 32'(bus.id), 32'(MID));
    check("rst_ready", 32'(job_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_job_id", 32'(job_id), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_release", 32'(job_ready), 32'd1);

    // Job with gnt tied high, acquire returns 3
    clear_log();
    rsp_q.push_back(32'h3);
    p = make_params(32'hA000_0000);
    send_job("t1", p);
    finish_job("t1", 8'h03);
    check_job_log("t1", 1, p);

    // Busy acquires twice, then context 1
    clear_log();
    rsp_q.push_back(32'hFFFF_FFFF);
    rsp_q.push_back(32'hFFFF_FFFF);
    rsp_q.push_back(32'h1);
    p = make_params(32'h1234_5000);
    send_job("t2", p);
    finish_job("t2", 8'h01);
    check_job_log("t2", 3, p);
    if (log_cyc.size() >= 3) begin
      check("t2_gap1", 32'((log_cyc[1] - log_cyc[0]) >= RETRY + 1), 32'd1);
      check("t2_gap2", 32'((log_cyc[2] - log_cyc[1]) >= RETRY + 1), 32'd1);
    end

    // Random grant stalls; an early evt during writes is ignored
    clear_log();
    gnt_random = 1;
    rsp_q.push_back(32'h5A);
    p = make_params(32'h0BAD_0000);
    send_job("t3", p);
    t = 0;
    while (log_add.size() < 6 && t < 500) begin @(negedge clk); t++; end
    evt = 1'b1;
    @(negedge clk);
    evt = 1'b0;
    @(negedge clk);
    check("t3_early_evt", 32'(done_cnt), 32'd0);
    finish_job("t3", 8'h5A);
    check_job_log("t3", 1, p);
    check("t3_stable", 32'(stable_err), 32'd0);
    gnt_random = 0;

    // Response with a foreign id first, then the real one
    clear_log();
    bad_id_next = 1;
    rsp_q.push_back(32'h2);
    p = make_params(32'h0C0F_FEE0);
    send_job("t4", p);
    finish_job("t4", 8'h02);
    check_job_log("t4", 1, p);

    // Reset during the idx=7 register write
    clear_log();
    rsp_q.push_back(32'h9);
    p = make_params(32'h7700_0000);
    send_job("t5", p);
    t = 0;
    while (!(bus.req && bus.add == BASE + 32'h5C) && t < 500) begin @(negedge clk); t++; end
    check("t5_at_idx7", bus.add, BASE + 32'h5C);
    #2 rst_n = 1'b0;
    #1;
    check("t5_req_drop", 32'(bus.req), 32'd0);
    check("t5_busy_drop", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    base_req = req_seen;
    repeat (30) @(negedge clk);
    check("t5_no_activity", 32'(req_seen - base_req), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);

    // Recovery job after the reset
    clear_log();
    rsp_q.push_back(32'h6);
    p = make_params(32'h5500_0000);
    send_job("t5r", p);
    finish_job("t5r", 8'h06);
    check_job_log("t5r", 1, p);

`ifdef VFPU_CFG_STATUS_POLL_EN
    // Status polling: busy, busy, done
    begin
      int n_stat;
      int stat_cyc[$];
      clear_log();
      rsp_q.push_back(32'h4);
      rsp_q.push_back(32'h1);
      rsp_q.push_back(32'h1);
      rsp_q.push_back(32'h0);
      p = make_params(32'h00C0_0000);
      send_job("poll", p);
      finish_job("poll", 8'h04);
      check_job_log("poll", 1, p);
      n_stat = 0;
      foreach (log_add[k]) begin
        if (log_add[k] == BASE + 32'h0C && log_wen[k]) begin
          n_stat++;
          stat_cyc.push_back(log_cyc[k]);
        end
      end
      check("poll_n_status", 32'(n_stat), 32'd3);
      if (stat_cyc.size() == 3) begin
        check("poll_gap1", 32'((stat_cyc[1] - stat_cyc[0]) >= POLL + 1), 32'd1);
        check("poll_gap2", 32'((stat_cyc[2] - stat_cyc[1]) >= POLL + 1), 32'd1);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
